// File: rtl/wb_commit_if.sv
// wb_commit_if: groups the commit-stage bus of wb_commit.
// master = instruction pipeline side (drives run, write-back requests and
// read indices); slave = the commit block (drives phase, pc, read data,
// retired count and misalign flag).
interface wb_commit_if;
  logic        run;
  logic [3:0]  start;
  logic        reg_update;
  logic [31:0] reg_new;
  logic [3:0]  rd;
  logic        pc_update;
  logic [31:0] pc_new;
  logic [31:0] pc;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [31:0] retired;
  logic        misalign;

  modport master (
    output run, reg_update, reg_new, rd, pc_update, pc_new, ra_addr, rb_addr,
    input  start, pc, ra_data, rb_data, retired, misalign
  );

  modport slave (
    input  run, reg_update, reg_new, rd, pc_update, pc_new, ra_addr, rb_addr,
    output start, pc, ra_data, rb_data, retired, misalign
  );
endinterface

// File: rtl/wb_commit.sv
// wb_commit: four-phase sequencer with architectural commit stage.
// A one-hot phase ring (fetch/decode/execute/write) advances while run=1.
// On the write phase edge the instruction commits: optional register write
// (r0 hard-wired to zero), pc redirect or pc+4, retired count increment and
// a sticky misalign flag for unaligned redirect targets.
// Optional feature: define WB_COMMIT_BYPASS_EN to forward reg_new onto a
// read port whose address matches the register being committed.
module wb_commit (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  bus
);

  logic [3:0]  r_start;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_misalign;
  logic        w_commit;
  logic [31:0] w_rf [16];
  logic [31:0] w_ra_data;
  logic [31:0] w_rb_data;

  // Commit happens only on the write phase while running; rst overrides
  // every register below, so a commit coinciding with reset is dropped.
  assign w_commit = bus.run & r_start[3];

  // Phase ring: rotate left while running, hold when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 4'b0001;
    end else if (bus.run) begin
      r_start <= {r_start[2:0], r_start[3]};
    end
  end

  // Program counter: redirect (word-aligned) or sequential advance on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (w_commit) begin
      if (bus.pc_update) begin
        r_pc <= {bus.pc_new[31:2], 2'b00};
      end else begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  // Sticky flag: any committed redirect with low address bits set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_commit && bus.pc_update && (bus.pc_new[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // Retired-instruction counter, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // Register file: r0 is a constant zero, r1..r15 are individual registers
  // so every entry can be cleared by reset.
  assign w_rf[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_rf
      logic [31:0] r_val;

      // Capture reg_new when this register is the committed destination.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_val <= '0;
        end else if (w_commit && bus.reg_update && (bus.rd == 4'(gi))) begin
          r_val <= bus.reg_new;
        end
      end

      assign w_rf[gi] = r_val;
    end
  endgenerate

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    w_ra_data = w_rf[bus.ra_addr];
    w_rb_data = w_rf[bus.rb_addr];
`ifdef WB_COMMIT_BYPASS_EN
    if (bus.run && r_start[3] && bus.reg_update && (bus.rd != 4'd0)) begin
      if (bus.ra_addr == bus.rd) w_ra_data = bus.reg_new;
      if (bus.rb_addr == bus.rd) w_rb_data = bus.reg_new;
    end
`endif
  end

  assign bus.start    = r_start;
  assign bus.pc       = r_pc;
  assign bus.retired  = r_retired;
  assign bus.misalign = r_misalign;
  assign bus.ra_data  = w_ra_data;
  assign bus.rb_data  = w_rb_data;

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: scoreboard bench for wb_commit. A reference model computes
// the expected post-edge state when each cycle's stimulus is driven; the
// entry is queued and compared one time unit after the clock edge.
module tb_wb_commit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_commit_if bus ();

  wb_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  start;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        misalign;
    logic [31:0] ra;
    logic [31:0] rb;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  // reference model state
  logic [3:0]  m_start;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_mis;
  logic [31:0] m_regs [16];
  logic        m_valid = 1'b0;
  logic [31:0] pre_ra;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = (a == 4'd0) ? 32'h0 : m_regs[a];
`ifdef WB_COMMIT_BYPASS_EN
    if (bus.run && m_start[3] && bus.reg_update && (bus.rd != 4'd0) && (a == bus.rd))
      v = bus.reg_new;
`endif
    return v;
  endfunction

  task automatic step(input logic s_rst, input logic s_run,
                      input logic s_ru, input logic [3:0] s_rd, input logic [31:0] s_rn,
                      input logic s_pu, input logic [31:0] s_pn,
                      input logic [3:0] s_ra, input logic [3:0] s_rb);
    exp_t e;
    exp_t got;
    logic commit;
    @(negedge clk);
    rst            = s_rst;
    bus.run        = s_run;
    bus.reg_update = s_ru;
    bus.rd         = s_rd;
    bus.reg_new    = s_rn;
    bus.pc_update  = s_pu;
    bus.pc_new     = s_pn;
    bus.ra_addr    = s_ra;
    bus.rb_addr    = s_rb;
    #1;
    pre_ra = bus.ra_data;
    if (m_valid) begin
      check_val("pre_ra", bus.ra_data, model_read(s_ra));
      check_val("pre_rb", bus.rb_data, model_read(s_rb));
    end
    // advance the model by one edge
    if (s_rst) begin
      m_start = 4'b0001;
      m_pc    = 32'h0;
      m_ret   = 32'h0;
      m_mis   = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      commit = s_run && m_start[3];
      if (commit) begin
        if (s_ru && (s_rd != 4'd0)) m_regs[s_rd] = s_rn;
        if (s_pu) begin
          m_pc = {s_pn[31:2], 2'b00};
          if (s_pn[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
        m_ret = m_ret + 32'd1;
      end
      if (s_run) m_start = {m_start[2:0], m_start[3]};
    end
    if (m_valid) begin
      e.start    = m_start;
      e.pc       = m_pc;
      e.retired  = m_ret;
      e.misalign = m_mis;
      e.ra       = model_read(s_ra);
      e.rb       = model_read(s_rb);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    n_cyc++;
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_val("start",    {28'h0, bus.start},   {28'h0, got.start});
      check_val("pc",       bus.pc,               got.pc);
      check_val("retired",  bus.retired,          got.retired);
      check_val("misalign", {31'h0, bus.misalign}, {31'h0, got.misalign});
      check_val("ra_data",  bus.ra_data,          got.ra);
      check_val("rb_data",  bus.rb_data,          got.rb);
    end
    $display("[TB] cyc=%0d rst=%0b run=%0b start=%b pc=%08h retired=%0d misalign=%0b ra=%08h rb=%08h",
             n_cyc, s_rst, s_run, bus.start, bus.pc, bus.retired, bus.misalign, bus.ra_data, bus.rb_data);
  endtask

  task automatic idle(input logic [3:0] s_ra, input logic [3:0] s_rb);
    step(1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, s_ra, s_rb);
  endtask

  task automatic to_write();
    for (int k = 0; k < 4 && !m_start[3]; k++) idle(4'd0, 4'd0);
  endtask

  task automatic cmt(input logic s_ru, input logic [3:0] s_rd, input logic [31:0] s_rn,
                     input logic s_pu, input logic [31:0] s_pn);
    to_write();
    step(1'b0, 1'b1, s_ru, s_rd, s_rn, s_pu, s_pn, 4'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ret_snap;
    bus.run = 1'b0; bus.reg_update = 1'b0; bus.rd = 4'd0; bus.reg_new = 32'h0;
    bus.pc_update = 1'b0; bus.pc_new = 32'h0; bus.ra_addr = 4'd0; bus.rb_addr = 4'd0;
    rst = 1'b1;

    // reset for two cycles, then run eight cycles
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0, 4'd0);
    check_val("rst_start", {28'h0, bus.start}, 32'h1);
    check_val("rst_pc", bus.pc, 32'h0);
    for (int i = 0; i < 4; i++) idle(4'd1, 4'd2);
    check_val("run4_pc", bus.pc, 32'h4);
    for (int i = 0; i < 4; i++) idle(4'd1, 4'd2);
    check_val("run8_pc", bus.pc, 32'h8);
    check_val("run8_retired", bus.retired, 32'd2);

    // register write and r0 discard
    cmt(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0);
    idle(4'd5, 4'd0);
    check_val("r5_write", bus.ra_data, 32'hDEADBEEF);
    cmt(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 32'h0);
    idle(4'd0, 4'd5);
    check_val("r0_read", bus.ra_data, 32'h0);

    // misaligned redirect, then aligned redirect keeps the sticky flag
    cmt(1'b0, 4'd0, 32'h0, 1'b1, 32'h00001003);
    check_val("redir_pc", bus.pc, 32'h00001000);
    check_val("redir_mis", {31'h0, bus.misalign}, 32'h1);
    cmt(1'b0, 4'd0, 32'h0, 1'b1, 32'h00002000);
    check_val("redir2_pc", bus.pc, 32'h00002000);
    check_val("redir2_mis", {31'h0, bus.misalign}, 32'h1);

    // stall in write phase
    to_write();
    ret_snap = bus.retired;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 4'd6, 32'hAAAA5555, 1'b0, 32'h0, 4'd6, 4'd0);
    check_val("stall_retired", bus.retired, ret_snap);
    check_val("stall_r6", bus.ra_data, 32'h0);
    step(1'b0, 1'b1, 1'b1, 4'd6, 32'hAAAA5555, 1'b0, 32'h0, 4'd6, 4'd0);
    check_val("unstall_retired", bus.retired, ret_snap + 32'd1);
    check_val("unstall_r6", bus.ra_data, 32'hAAAA5555);

    // pc wrap and simultaneous register/pc update
    cmt(1'b0, 4'd0, 32'h0, 1'b1, 32'hFFFFFFFC);
    cmt(1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
    check_val("pc_wrap", bus.pc, 32'h0);
    ret_snap = bus.retired;
    cmt(1'b1, 4'd7, 32'h12345678, 1'b1, 32'h00000400);
    check_val("both_pc", bus.pc, 32'h00000400);
    check_val("both_retired", bus.retired, ret_snap + 32'd1);
    idle(4'd7, 4'd6);
    check_val("both_r7", bus.ra_data, 32'h12345678);

    // reset on a commit edge drops the commit
    to_write();
    step(1'b1, 1'b1, 1'b1, 4'd8, 32'hCAFEF00D, 1'b1, 32'h00000800, 4'd8, 4'd5);
    check_val("rstc_pc", bus.pc, 32'h0);
    check_val("rstc_retired", bus.retired, 32'h0);
    check_val("rstc_r8", bus.ra_data, 32'h0);
    check_val("rstc_r5", bus.rb_data, 32'h0);

    // write-phase forwarding on the read port
    cmt(1'b1, 4'd3, 32'h00000033, 1'b0, 32'h0);
    to_write();
    step(1'b0, 1'b1, 1'b1, 4'd3, 32'h00000007, 1'b0, 32'h0, 4'd3, 4'd0);
`ifdef WB_COMMIT_BYPASS_EN
    check_val("bypass_ra", pre_ra, 32'h00000007);
`else
    check_val("bypass_ra", pre_ra, 32'h00000033);
`endif

    // random traffic
    for (int i = 0; i < 120; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 4'($urandom), $urandom(),
           ($urandom_range(0, 3) == 0), $urandom(),
           4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, synchronous, active-high, sampled only on the clk rising edge.
REQ-002 The block SHALL provide input run, 1 bit: phase-advance enable; 0 freezes all state.
REQ-003 The block SHALL provide output start, 4 bits, one-hot phase: bit0 fetch, bit1 decode, bit2 execute, bit3 write.
REQ-004 The block SHALL provide input reg_update, 1 bit: the write stage requests a register write.
REQ-005 The block SHALL provide input reg_new, 32 bits: the register write data.
REQ-006 The block SHALL provide input rd, 4 bits: the destination register index.
REQ-007 The block SHALL provide input pc_update, 1 bit: the write stage requests a PC redirect.
REQ-008 The block SHALL provide input pc_new, 32 bits: the redirect target.
REQ-009 The block SHALL provide output pc, 32 bits: the architectural program counter.
REQ-010 The block SHALL provide inputs ra_addr and rb_addr, 4 bits each: asynchronous read-port indices.
REQ-011 The block SHALL provide outputs ra_data and rb_data, 32 bits each: the read-port data.
REQ-012 The block SHALL provide output retired, 32 bits: the count of committed instructions.
REQ-013 The block SHALL provide output misalign, 1 bit: a sticky flag set by a misaligned redirect.

Function
REQ-014 The phase ring SHALL rotate left one position per clk edge when run=1, with start[3] wrapping to start[0].
REQ-015 The phase ring SHALL hold its value when run=0.
REQ-016 A commit edge SHALL be any clk edge with run=1, start[3]=1 and rst=0; state SHALL change only on commit edges, except the phase ring.
REQ-017 On a commit edge with reg_update=1 and rd!=0, regfile[rd] SHALL take reg_new.
REQ-018 Writes to r0 SHALL be discarded.
REQ-019 On a commit edge with pc_update=1, pc SHALL take {pc_new[31:2],2'b00}.
REQ-020 If pc_new[1:0]!=0 on such an edge, misalign SHALL be set to 1; it SHALL stay 1 until reset.
REQ-021 On a commit edge with pc_update=0, pc SHALL take pc+4, modulo 2^32; 32'hFFFFFFFC SHALL wrap to 0.
REQ-022 When reg_update=1 and pc_update=1 on the same commit edge, both updates SHALL apply in that cycle.
REQ-023 retired SHALL increment by 1 on every commit edge, wrapping from 32'hFFFFFFFF to 0.
REQ-024 The read ports SHALL be combinational, and index 0 SHALL read 32'h0.
REQ-025 Without the Configuration feature, a read of rd during a commit edge SHALL return the pre-commit value.
REQ-026 reg_update, pc_update, rd, reg_new and pc_new SHALL be ignored on all non-commit edges.
REQ-027 Commit latency SHALL be one edge: new values are visible on outputs immediately after the commit edge.

Reset
REQ-028 When rst=1, the block SHALL set start=4'b0001, pc=32'h0, retired=0, misalign=0 and regfile[1..15]=0.
REQ-029 rst SHALL take priority over run and over any commit in the same cycle; the pending commit is dropped.
REQ-030 A reset arriving mid-instruction (any phase) SHALL return the ring to fetch and discard partial work.

Configuration
REQ-031 With the macro WB_COMMIT_BYPASS_EN defined, when start[3]=1, run=1, reg_update=1 and rd!=0, a read port whose address equals rd SHALL return reg_new combinationally.
REQ-032 Without WB_COMMIT_BYPASS_EN, the read ports SHALL return stored values only, as stated in REQ-025.
REQ-033 Index 0 SHALL read 0 in both builds.

Verification
REQ-034 Reset test: rst=1 for 2 cycles, then run=1 for 8 cycles -> start=0001,0010,0100,1000,0001...; pc=0 then 4 then 8; retired=2.
REQ-035 Register write test: in write phase, reg_update=1, rd=5, reg_new=32'hDEADBEEF -> after the edge, ra_addr=5 gives DEADBEEF; rd=0 with the same data -> ra_data for index 0 = 0.
REQ-036 Redirect test: pc_update=1, pc_new=32'h00001003 -> pc=32'h00001000, misalign=1, which persists after a later aligned redirect to 32'h2000 (pc=2000).
REQ-037 Stall test: run=0 during write phase with reg_update=1 for 3 cycles -> no write and retired unchanged; run=1 -> exactly one commit.
REQ-038 Wrap/simultaneous test: pc=32'hFFFFFFFC with no redirect -> pc=0; reg_update and pc_update together -> both applied, retired +1; rst asserted on a commit edge -> no write, state at reset values.
REQ-039 Bypass test: in write phase with rd=3, reg_new=7, ra_addr=3 before the edge -> ra_data=7 when WB_COMMIT_BYPASS_EN is defined, old value when it is not.
